es8388_init_ctrl: RTL and testbench

ES8388_INIT_CTRL -- requirements
Module: es8388_init_ctrl

---
 rtl/es8388_pkg.sv | 23 ++
 rtl/es8388_delay_timer.sv | 34 +++
 rtl/es8388_init_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_es8388_init_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/es8388_pkg.sv
// rtl/es8388_pkg.sv - shared FSM states, codec register constants and delay sizing for the ES8388 init controller
package es8388_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0] REG_PWR = 8'h02;
  localparam logic [7:0] REG_RST = 8'h00;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/es8388_delay_timer.sv
// rtl/es8388_delay_timer.sv - loadable down-counter; expired_o is high once the loaded count has run out
module es8388_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] cycles_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so an idle timer never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cycles_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/es8388_init_ctrl.sv
// rtl/es8388_init_ctrl.sv - walks the codec register table, issuing I2C writes with reset/power-up waits
// Define ES8388_INIT_RETRY_EN to retry NACKed writes up to MAX_RETRY times before failing.
module es8388_init_ctrl
  import es8388_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ  = 50_000_000,
  parameter int unsigned RST_WAIT_MS = 100,
  parameter int unsigned PWR_WAIT_MS = 500,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_q,
  input  logic [7:0]  tbl_dev_id,
  input  logic [7:0]  tbl_lut_size,
  output logic        wr_req,
  output logic [7:0]  wr_dev,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_data,
  input  logic        wr_done,
  input  logic        wr_ack_err,
  output logic        busy,
  output logic        init_done,
  output logic        init_err,
  output logic [7:0]  err_idx
);

  localparam int unsigned RST_CYC = ms_to_cycles(SYS_CLK_HZ, RST_WAIT_MS);
  localparam int unsigned PWR_CYC = ms_to_cycles(SYS_CLK_HZ, PWR_WAIT_MS);
  localparam int unsigned MAX_CYC = (RST_CYC > PWR_CYC) ? RST_CYC : PWR_CYC;
  localparam int DLY_W = (MAX_CYC == 0) ? 1 : $clog2(MAX_CYC + 1);
  localparam logic [DLY_W-1:0] RST_CNT = DLY_W'(RST_CYC);
  localparam logic [DLY_W-1:0] PWR_CNT = DLY_W'(PWR_CYC);

  state_e     state_q, state_d;
  logic [7:0] tbl_addr_q, tbl_addr_d;
  logic [7:0] wr_dev_q, wr_dev_d;
  logic [7:0] wr_reg_q, wr_reg_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       init_done_q, init_done_d;
  logic       init_err_q, init_err_d;
  logic [7:0] err_idx_q, err_idx_d;
`ifdef ES8388_INIT_RETRY_EN
  localparam int RTY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry_q, retry_d;
`endif

  logic             dly_load;
  logic [DLY_W-1:0] dly_cycles;
  logic             dly_expired;
  logic             go_err;
  logic             is_rst_wr, is_pwr_wr;

  assign is_rst_wr = (wr_reg_q == REG_RST) && wr_data_q[7];
  assign is_pwr_wr = (wr_reg_q == REG_PWR) && (wr_data_q == 8'h00);

  es8388_delay_timer #(.W(DLY_W)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load_i   (dly_load),
    .cycles_i (dly_cycles),
    .expired_o(dly_expired)
  );

  always_comb begin
    state_d     = state_q;
    tbl_addr_d  = tbl_addr_q;
    wr_dev_d    = wr_dev_q;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    init_done_d = init_done_q;
    init_err_d  = init_err_q;
    err_idx_d   = err_idx_q;
`ifdef ES8388_INIT_RETRY_EN
    retry_d     = retry_q;
`endif
    dly_load    = 1'b0;
    dly_cycles  = '0;
    go_err      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          init_done_d = 1'b0;
          init_err_d  = 1'b0;
          err_idx_d   = 8'h00;
          tbl_addr_d  = 8'h00;
          if (tbl_lut_size == 8'h00) begin
            state_d     = ST_DONE;
            init_done_d = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        wr_reg_d  = tbl_q[15:8];
        wr_data_d = tbl_q[7:0];
        wr_dev_d  = tbl_dev_id;
`ifdef ES8388_INIT_RETRY_EN
        retry_d   = '0;
`endif
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (wr_done) begin
          if (wr_ack_err) begin
`ifdef ES8388_INIT_RETRY_EN
            if (32'(retry_q) < MAX_RETRY) begin
              retry_d = retry_q + 1'b1;
              state_d = ST_ISSUE;
            end else begin
              go_err = 1'b1;
            end
`else
            go_err = 1'b1;
`endif
          end else if (is_rst_wr) begin
            dly_load   = 1'b1;
            dly_cycles = RST_CNT;
            state_d    = ST_DELAY;
          end else if (is_pwr_wr) begin
            dly_load   = 1'b1;
            dly_cycles = PWR_CNT;
            state_d    = ST_DELAY;
          end else begin
            state_d = ST_NEXT;
          end
        end
      end
      ST_DELAY: begin
        if (dly_expired) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        tbl_addr_d = tbl_addr_q + 8'd1;
        if (tbl_addr_d == tbl_lut_size) begin
          state_d     = ST_DONE;
          init_done_d = 1'b1;
        end else begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // err_idx captures the entry that was being written when the NACK landed.
    if (go_err) begin
      state_d    = ST_ERR;
      init_err_d = 1'b1;
      err_idx_d  = tbl_addr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tbl_addr_q  <= 8'h00;
      wr_dev_q    <= 8'h00;
      wr_reg_q    <= 8'h00;
      wr_data_q   <= 8'h00;
      init_done_q <= 1'b0;
      init_err_q  <= 1'b0;
      err_idx_q   <= 8'h00;
`ifdef ES8388_INIT_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tbl_addr_q  <= tbl_addr_d;
      wr_dev_q    <= wr_dev_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
      init_err_q  <= init_err_d;
      err_idx_q   <= err_idx_d;
`ifdef ES8388_INIT_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign tbl_addr  = tbl_addr_q;
  assign wr_req    = (state_q == ST_ISSUE);
  assign wr_dev    = wr_dev_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign init_done = init_done_q;
  assign init_err  = init_err_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_es8388_init_ctrl.sv
// tb/tb_es8388_init_ctrl.sv - scoreboard bench: table ROM, I2C engine model, write monitor and reference model
module tb_es8388_init_ctrl;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned RST_MS  = 2;
  localparam int unsigned PWR_MS  = 5;
  localparam int unsigned MAXR    = 3;
  localparam int          RST_CYC = CLK_HZ / 1000 * RST_MS;
  localparam int          PWR_CYC = CLK_HZ / 1000 * PWR_MS;
  localparam int          GAP_SLACK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_q = 16'h0;
  logic [7:0]  tbl_dev_id = 8'h20;
  logic [7:0]  tbl_lut_size = 8'h0;
  logic        wr_req;
  logic [7:0]  wr_dev, wr_reg, wr_data;
  logic        wr_done, wr_ack_err;
  logic        busy, init_done, init_err;
  logic [7:0]  err_idx;
  logic        eng_done = 1'b0, eng_nack = 1'b0, stray_done = 1'b0;

  assign wr_done    = eng_done | stray_done;
  assign wr_ack_err = eng_nack;

  es8388_init_ctrl #(
    .SYS_CLK_HZ(CLK_HZ), .RST_WAIT_MS(RST_MS), .PWR_WAIT_MS(PWR_MS), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr), .tbl_q(tbl_q),
    .tbl_dev_id(tbl_dev_id), .tbl_lut_size(tbl_lut_size), .wr_req(wr_req),
    .wr_dev(wr_dev), .wr_reg(wr_reg), .wr_data(wr_data), .wr_done(wr_done),
    .wr_ack_err(wr_ack_err), .busy(busy), .init_done(init_done),
    .init_err(init_err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:255];
  int          nack_plan [0:255];
  int          nack_left [0:255];
  int          eng_lat = 4;
  bit          stray_mode = 1'b0;

  always @(posedge clk) tbl_q <= rom[tbl_addr];

  typedef struct {
    logic [7:0] dev;
    logic [7:0] rg;
    logic [7:0] dat;
    int         dly;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  nreq = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // I2C engine: answers each wr_req after eng_lat cycles, NACKing per the plan for that entry.
  initial begin : engine
    int  idx;
    bit  nk, rtype;
    @(posedge clk); #1;
    forever begin
      if (!rst && wr_req) begin
        idx   = int'(tbl_addr);
        nk    = nack_left[idx] > 0;
        if (nk) nack_left[idx]--;
        rtype = (wr_reg == 8'h00 && wr_data[7]) || (wr_reg == 8'h02 && wr_data == 8'h00);
        repeat (eng_lat) begin @(posedge clk); #1; end
        if (!rst) begin eng_done = 1'b1; eng_nack = nk; end
        @(posedge clk); #1;
        eng_done = 1'b0; eng_nack = 1'b0;
        if (stray_mode && !nk && rtype && !rst) begin
          stray_done = 1'b1;
          @(posedge clk); #1;
          stray_done = 1'b0;
        end
      end else begin
        if (!busy) begin
          for (int i = 0; i < 256; i++) nack_left[i] = nack_plan[i];
        end
        @(posedge clk); #1;
      end
    end
  end

  // Monitor: pops the expected write on every wr_req and checks operands and inter-write gaps.
  initial begin : monitor
    wr_t cur;
    bit  holding, gap_armed;
    int  gap, gap_min;
    holding = 0; gap_armed = 0; gap = 0; gap_min = 0;
    cur = '{dev: 8'h0, rg: 8'h0, dat: 8'h0, dly: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 0; gap_armed = 0;
        exp_q.delete();
      end else begin
        if (!busy) gap_armed = 0;
        if (gap_armed) gap++;
        if (holding && !wr_req) check("operands_held", {wr_dev, wr_reg, wr_data}, {cur.dev, cur.rg, cur.dat});
        if (wr_req) begin
          nreq++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_wr_req actual=reg 0x%0h data 0x%0h required=no write", wr_reg, wr_data);
          end else begin
            cur = exp_q.pop_front();
            check("wr_operands", {wr_dev, wr_reg, wr_data}, {cur.dev, cur.rg, cur.dat});
            if (gap_armed) begin
              checks++;
              if (gap < gap_min || gap > gap_min + GAP_SLACK) begin
                failures++;
                $display("FAIL idle_gap actual=%0d required=%0d..%0d", gap, gap_min, gap_min + GAP_SLACK);
              end
            end
            holding = 1;
          end
          gap_armed = 0;
        end
        if (eng_done) begin
          holding = 0;
          if (!eng_nack) begin gap_armed = 1; gap = 0; gap_min = cur.dly; end
        end
      end
    end
  end

  // Reference model: derives the write sequence and outcome from table contents and NACK plan.
  task automatic build_model(input int n, output int writes, output bit err, output int eidx);
    wr_t w;
    writes = 0; err = 0; eidx = 0;
    for (int i = 0; i < n; i++) begin
      w.dev = tbl_dev_id;
      w.rg  = rom[i][15:8];
      w.dat = rom[i][7:0];
      w.dly = 0;
`ifdef ES8388_INIT_RETRY_EN
      for (int a = 0; a < nack_plan[i] && a <= int'(MAXR); a++) begin
        exp_q.push_back(w); writes++;
      end
      if (nack_plan[i] > int'(MAXR)) begin err = 1; eidx = i; break; end
`else
      if (nack_plan[i] > 0) begin
        exp_q.push_back(w); writes++;
        err = 1; eidx = i; break;
      end
`endif
      if (w.rg == 8'h00 && w.dat[7]) w.dly = RST_CYC;
      else if (w.rg == 8'h02 && w.dat == 8'h00) w.dly = PWR_CYC;
      exp_q.push_back(w); writes++;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_case(input string tag, input int n, input bit poke_start, input int max_cycles);
    int  writes, eidx, base, cyc;
    bit  err, finished;
    tbl_lut_size = 8'(n);
    build_model(n, writes, err, eidx);
    base = nreq;
    pulse_start();
    finished = 0;
    for (cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (poke_start && cyc == 10) start = 1'b1;
      if (poke_start && cyc == 11) start = 1'b0;
      if (!busy && (init_done || init_err)) begin finished = 1; break; end
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=still busy required=finished within 3000 cycles", tag);
    end else if (max_cycles > 0) begin
      checks++;
      if (cyc > max_cycles) begin
        failures++;
        $display("FAIL %s_latency actual=%0d required<=%0d", tag, cyc, max_cycles);
      end
    end
    check({tag, "_init_done"}, init_done, !err);
    check({tag, "_init_err"}, init_err, err);
    check({tag, "_err_idx"}, err_idx, err ? eidx : 0);
    check({tag, "_tbl_addr"}, tbl_addr, err ? eidx : n);
    check({tag, "_wr_req_count"}, nreq - base, writes);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_ref_table();
    rom[0] = 16'h0080; rom[1] = 16'h0150; rom[2] = 16'h0200;
    for (int i = 0; i < 256; i++) nack_plan[i] = 0;
    tbl_dev_id = 8'h20;
    eng_lat = 4;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=no finish required=finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, k, base;
    bit hit;
    for (int i = 0; i < 256; i++) begin rom[i] = 16'h0; nack_plan[i] = 0; nack_left[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_wr_req", wr_req, 0);
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_err", init_err, 0);
    check("rst_err_idx", err_idx, 0);
    check("rst_operands", {wr_dev, wr_reg, wr_data}, 0);

    load_ref_table();
    run_case("ref_table", 3, 0, 0);
    run_case("empty_table", 0, 0, 2);

    load_ref_table();
    nack_plan[1] = 1;
    run_case("nack_once", 3, 0, 0);
    nack_plan[1] = 2;
    run_case("nack_twice", 3, 0, 0);
    nack_plan[1] = 4;
    run_case("nack_four", 3, 0, 0);

    load_ref_table();
    stray_mode = 1'b1;
    run_case("busy_start_stray", 3, 1, 0);
    stray_mode = 1'b0;

    // Reset in the middle of the power-up wait, then rerun from entry 0.
    load_ref_table();
    tbl_lut_size = 8'd3;
    begin
      int w, e; bit er;
      build_model(3, w, er, e);
    end
    pulse_start();
    hit = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (eng_done && !eng_nack && wr_reg == 8'h02 && wr_data == 8'h00) begin hit = 1; break; end
    end
    check("pwr_ack_reached", hit, 1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_outputs", {tbl_addr, wr_req, wr_dev, wr_reg, wr_data, init_done, init_err, err_idx}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    base = nreq;
    repeat (6) @(negedge clk);
    check("no_autostart_busy", busy, 0);
    check("no_autostart_wr_req", nreq - base, 0);
    run_case("rerun_after_rst", 3, 0, 0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      tbl_dev_id = 8'($urandom);
      eng_lat = $urandom_range(1, 6);
      for (int i = 0; i < 256; i++) nack_plan[i] = 0;
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 3);
        case (k)
          0: rom[i] = {8'h00, 8'($urandom)};
          1: rom[i] = {8'h02, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom)};
          default: rom[i] = 16'($urandom);
        endcase
        if ($urandom_range(0, 4) == 0) nack_plan[i] = $urandom_range(1, 4);
      end
      run_case("random", n, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
